// File: rtl/craft_key_register_dec_if.sv
// Bus between the CRAFT decryption key register and its consumer.
// Handshake: `valid` marks a meaningful nibble, and `en` acts as the consumer's
// ready. A nibble is consumed on every rising edge where valid & en are both 1.
// Otherwise out/rc/round/nib_idx/first hold. `start` is taken only while busy is low.
interface craft_key_register_dec_if;
  logic         start;
  logic         en;
  logic [127:0] key;
  logic [63:0]  tweak;
  logic [3:0]   out;
  logic [7:0]   rc;
  logic [4:0]   round;
  logic [3:0]   nib_idx;
  logic         first;
  logic         valid;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  modport master (
    output start, en, key, tweak,
    input  out, rc, round, nib_idx, first, valid, busy, done, state_dbg
  );

  modport slave (
    input  start, en, key, tweak,
    output out, rc, round, nib_idx, first, valid, busy, done, state_dbg
  );
endinterface

// File: rtl/craft_key_register_dec.sv
// Nibble-serial CRAFT decryption tweakey / round-constant generator.
// Walks rounds NROUNDS-1 down to 0, streaming TK(r mod 4) MSB-nibble first.
module craft_key_register_dec #(
  parameter int NROUNDS = 32
) (
  input logic                      clk,
  input logic                      rst,
  craft_key_register_dec_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] QIDX [16] = '{4'd12, 4'd10, 4'd15, 4'd5, 4'd14, 4'd8, 4'd9, 4'd2,
                                       4'd11, 4'd3,  4'd7,  4'd4, 4'd6,  4'd0, 4'd1, 4'd13};
  // RC register values for the first emitted round (a=8, b=5 -> rc=0x85).
  localparam logic [3:0] A_START = 4'h8;
  localparam logic [2:0] B_START = 3'h5;

  state_e      state_q, state_d;
  logic [63:0] k0_q, k0_d, k1_q, k1_d, t_q, t_d;
  logic [4:0]  round_q, round_d;
  logic [3:0]  nib_q, nib_d;
  logic [3:0]  a_q, a_d;
  logic [2:0]  b_q, b_d;

  logic        accept;
  logic        step;
  logic        last;
  logic [63:0] qt;
  logic [63:0] tk;
  logic [3:0]  tk_nib;

  assign accept = bus.start && (state_q != S_RUN);
  assign step   = (state_q == S_RUN) && bus.en;
  assign last   = step && (nib_q == 4'hF) && (round_q == 5'd0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; S_DONE is idle-like so a start there is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last)      state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy      = (state_q == S_RUN);
    bus.valid     = (state_q == S_RUN);
    bus.done      = (state_q == S_DONE);
    bus.first     = (state_q == S_RUN) && (nib_q == 4'd0);
    bus.out       = (state_q == S_RUN) ? tk_nib : 4'd0;
    bus.rc        = (state_q == S_RUN) ? {a_q, 1'b0, b_q} : 8'd0;
    bus.round     = round_q;
    bus.nib_idx   = nib_q;
    bus.state_dbg = state_q;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k0_q    <= '0;
      k1_q    <= '0;
      t_q     <= '0;
      round_q <= '0;
      nib_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      k0_q    <= k0_d;
      k1_q    <= k1_d;
      t_q     <= t_d;
      round_q <= round_d;
      nib_q   <= nib_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    k0_d    = k0_q;
    k1_d    = k1_q;
    t_d     = t_q;
    round_d = round_q;
    nib_d   = nib_q;
    a_d     = a_q;
    b_d     = b_q;
    if (accept) begin
      k0_d    = bus.key[127:64];
      k1_d    = bus.key[63:0];
      t_d     = bus.tweak;
      round_d = 5'(NROUNDS - 1);
      nib_d   = 4'd0;
      a_d     = A_START;
      b_d     = B_START;
    end else if (step) begin
      if (nib_q == 4'hF) begin
        nib_d = 4'd0;
        if (round_q != 5'd0) begin
          // Inverse of the encryption-direction LFSR steps.
          round_d = round_q - 5'd1;
          a_d     = {a_q[2:0], a_q[3] ^ a_q[0]};
          b_d     = {b_q[1:0], b_q[2] ^ b_q[0]};
        end else begin
          a_d = 4'd0;
          b_d = 3'd0;
        end
      end else begin
        nib_d = nib_q + 4'd1;
      end
    end
  end

  // Q(T): output nibble j takes tweak nibble QIDX[j]; nibble 0 is bits [63:60].
  always_comb begin
    qt = '0;
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) begin
        if (QIDX[j] == 4'(i)) qt[63-4*j -: 4] = t_q[63-4*i -: 4];
      end
    end
  end

  // round[0] picks K1 over K0, round[1] picks Q(T) over T.
  always_comb begin
    tk     = (round_q[0] ? k1_q : k0_q) ^ (round_q[1] ? qt : t_q);
    tk_nib = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (nib_q == 4'(i)) tk_nib = tk[63-4*i -: 4];
    end
  end

endmodule

// File: tb/tb_craft_key_register_dec.sv
// Randomized scoreboard bench for craft_key_register_dec against a
// round-by-round reference model built from the tweakey and RC rules.
module tb_craft_key_register_dec;

  logic clk = 1'b0;
  logic rst;

  craft_key_register_dec_if bus ();

  craft_key_register_dec #(.NROUNDS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] SPEC_KEY = 128'h27a6781a43f364bc916708d5fbb5aefe;
  localparam logic [63:0]  SPEC_TW  = 64'h54cd94ffd0670a58;
  localparam int QP [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

  int          checks = 0;
  int          errors = 0;
  logic [21:0] exp_q[$];
  int          exp_done = 0;
  int          got_done = 0;
  int          cons_cnt = 0;
  bit          en_rand  = 0;
  bit          scramble = 0;
  bit          cap_en   = 0;
  logic [63:0] cap_tk [32];
  logic [7:0]  cap_rc [32];
  logic [7:0]  rc_tab [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Round constants walked forward from round 0 (a=1, b=1).
  task automatic build_rc();
    logic [3:0] a;
    logic [2:0] b;
    a = 4'd1;
    b = 3'd1;
    for (int r = 0; r < 32; r++) begin
      rc_tab[r] = {a, 1'b0, b};
      a = {a[0] ^ a[1], a[3:1]};
      b = {b[0] ^ b[1], b[2:1]};
    end
  endtask

  function automatic logic [63:0] qperm(input logic [63:0] t);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[60-4*j +: 4] = t[60-4*QP[j] +: 4];
    return r;
  endfunction

  // Expected entry: {round, nib_idx, out, rc, first}.
  task automatic push_model(input logic [127:0] key, input logic [63:0] tw);
    logic [63:0] k0, k1, qt, tk;
    k0 = key[127:64];
    k1 = key[63:0];
    qt = qperm(tw);
    for (int r = 31; r >= 0; r--) begin
      case (r % 4)
        0:       tk = k0 ^ tw;
        1:       tk = k1 ^ tw;
        2:       tk = k0 ^ qt;
        default: tk = k1 ^ qt;
      endcase
      for (int n = 0; n < 16; n++)
        exp_q.push_back({5'(r), 4'(n), tk[60-4*n +: 4], rc_tab[r], (n == 0)});
    end
  endtask

  task automatic drive_start(input logic [127:0] key, input logic [63:0] tw);
    bus.key   = key;
    bus.tweak = tw;
    bus.start = 1'b1;
    push_model(key, tw);
    exp_done++;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < max_cycles);
    check("done_seen", bus.done, 1);
  endtask

  task automatic check_idle(input string name);
    check(name, {bus.out, bus.rc, bus.round, bus.nib_idx, bus.first, bus.valid, bus.busy, bus.done}, 0);
  endtask

  // en driver: all-ones or ~50% random stalls
  initial begin
    forever begin
      @(posedge clk);
      #1 bus.en = en_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Key/tweak inputs churn while a sequence is running
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (scramble && bus.busy) begin
        bus.key   = {$urandom, $urandom, $urandom, $urandom};
        bus.tweak = {$urandom, $urandom};
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [21:0] snap, prev_snap, e;
    bit          prev_stall;
    logic        prev_busy;
    int          base;
    prev_snap  = '0;
    prev_stall = 0;
    prev_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        prev_busy  = 1'b0;
      end else begin
        snap = {bus.round, bus.nib_idx, bus.out, bus.rc, bus.first};
        if (prev_stall) check("hold_on_stall", snap, prev_snap);
        if (bus.busy && !prev_busy) cons_cnt = 0;
        if (bus.valid && bus.en) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_nibble actual=%h expected=none t=%0t", snap, $time);
          end else begin
            e = exp_q.pop_front();
            check("nibble", snap, e);
          end
          if (cap_en) begin
            base = 60 - 4 * int'(bus.nib_idx);
            cap_tk[bus.round][base +: 4] = bus.out;
            cap_rc[bus.round] = bus.rc;
          end
          cons_cnt++;
        end
        if (bus.done) begin
          got_done++;
          check("done_latency", 64'(cons_cnt), 512);
          check("done_outputs", {bus.valid, bus.busy, bus.out, bus.rc, bus.round, bus.nib_idx, bus.first}, 0);
        end
        prev_snap  = snap;
        prev_stall = bus.valid && !bus.en;
        prev_busy  = bus.busy;
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.en    = 1'b1;
    bus.key   = '0;
    bus.tweak = '0;
    rst       = 1'b1;
    build_rc();

    // Clock/reset
    repeat (3) @(posedge clk);
    #1 check_idle("reset_outputs");
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    check_idle("idle_after_reset");

    // Known vector, en held high
    cap_en = 1;
    @(posedge clk);
    #1 drive_start(SPEC_KEY, SPEC_TW);
    @(negedge clk);
    check("first_round", {bus.round, bus.rc, bus.first}, {5'd31, 8'h85, 1'b1});
    wait_done(700);
    cap_en = 0;
    check("r31_stream", cap_tk[31], 64'h97e355d9864c5bb4);
    check("r30_stream", cap_tk[30], 64'h212225163e0a91f6);
    check("r28_stream", cap_tk[28], 64'h736bece593946ee4);
    check("r31_rc", cap_rc[31], 8'h85);
    check("r30_rc", cap_rc[30], 8'h12);
    check("r29_rc", cap_rc[29], 8'h34);
    check("r0_rc",  cap_rc[0],  8'h11);

    // Start on the done cycle; random stalls and churning key/tweak inputs
    en_rand  = 1;
    scramble = 1;
    drive_start(SPEC_KEY, SPEC_TW);
    @(negedge clk);
    check("restart_round", {bus.valid, bus.round, bus.rc}, {1'b1, 5'd31, 8'h85});
    begin
      int n;
      n = 0;
      while (!(bus.round == 5'd17 && bus.nib_idx == 4'd5) && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check("reach_r17_n5", {bus.round, bus.nib_idx}, {5'd17, 4'd5});
      bus.key   = {$urandom, $urandom, $urandom, $urandom};
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    wait_done(3000);

    // Random key, restart on done, then abort with a mid-stream reset
    drive_start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
    repeat ($urandom_range(50, 300)) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_idle("async_reset_abort");
    exp_q.delete();
    exp_done--;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_after_abort", {bus.busy, bus.done, bus.valid}, 0);
    end

    check("done_count", 64'(got_done), 64'(exp_done));
    check("queue_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
